mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch requester (IFU) and load/store requester (LSU).
- Grants one requester at a time and latches its request payload.
- Drives the downstream memory handshake and returns the response only to the granted requester.
- Sits between cpu (io_ifu_*/io_lsu_*) and the single memory slave in the SoC top.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 255, WAIT-state cycle limit (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ifu_reqValid  in  1  IFU request, level, held until ifu_respValid
ifu_addr  in  ADDR_W  fetch address
ifu_respValid  out  1  one-cycle response pulse to IFU
ifu_rdata  out  DATA_W  fetch data, valid with ifu_respValid
lsu_reqValid  in  1  LSU request, level, held until lsu_respValid
lsu_addr  in  ADDR_W  load/store address
lsu_size  in  2  0=byte, 1=half, 2=word
lsu_wen  in  1  1=store
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  4  byte strobes
lsu_respValid  out  1  one-cycle response pulse to LSU
lsu_rdata  out  DATA_W  load data, valid with lsu_respValid
mem_reqValid  out  1  downstream request
mem_reqReady  in  1  downstream accept
mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/2/1/DATA_W/4  latched payload
mem_respValid  in  1  downstream response pulse
mem_rdata  in  DATA_W  downstream read data
resp_err  out  1  pulses with a requester's respValid on timeout; constant 0 when MEM_ARB_TIMEOUT_EN is undefined

Behaviour:
- Reset: every output is 0, state is IDLE, and last_grant is IFU. Reset mid-transaction abandons the transaction and issues no respValid.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: arbitration and payload capture.
  - Only one requester valid: grant it.
  - Both valid: grant the requester not equal to last_grant (round-robin), so LSU wins the first tie after reset.
  - On grant: latch the payload into the mem_* registers (IFU grant forces size=2, wen=0, wmask=4'b1111, wdata=0), update last_grant, then go to REQ.
- REQ: mem_reqValid=1 with a stable payload. When mem_reqReady=1, go to WAIT on the next edge. mem_respValid is ignored in REQ.
- WAIT: mem_reqValid=0. When mem_respValid=1, register mem_rdata and go to DONE.
- DONE: the granted requester's respValid=1 for exactly one cycle, with its rdata equal to the registered value. The other requester sees respValid=0. Next state is IDLE.
- Requester contract: deassert reqValid on the edge ending the respValid cycle unless issuing a new request. The DONE state guarantees no spurious re-grant.
- Latency: minimum 3 cycles from reqValid rising to respValid (IDLE→REQ→WAIT→DONE), with mem_reqReady=1 in REQ and mem_respValid=1 in the first WAIT cycle.
- rdata outputs hold their last value outside DONE. Stores also complete through DONE; rdata contents are don't-care for stores.
- A requester raising reqValid while the other is granted waits in IDLE arbitration. Its payload is sampled only at its own grant.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without mem_respValid, go to DONE with rdata=32'hDEADBEEF and resp_err=1 for that cycle.
  - mem_respValid arriving in the same cycle the limit is reached takes priority and produces a normal response.
- MEM_ARB_TIMEOUT_EN undefined: WAIT persists indefinitely, no counter is synthesized, and resp_err is tied 0.

Decomposition:
- Package mem_arb_pkg holds: the state enum (IDLE, REQ, WAIT, DONE), the grant enum (GNT_IFU, GNT_LSU), size encodings, and the DEADBEEF constant.
- One sub-module: arb_rr2, a combinational two-way round-robin picker. Inputs: the two valids and last_grant. Outputs: grant_valid and grant_id.

Test Plan:
- IFU-only fetch: ifu_addr=0x8000_0000, mem_reqReady=1, mem_respValid in first WAIT with rdata=0x0010_0093 → ifu_respValid pulses 1 cycle at cycle 3 with ifu_rdata=0x0010_0093; lsu_respValid stays 0.
- Store: lsu_addr=0x100, lsu_wen=1, lsu_wmask=4'b0011, lsu_wdata=0xBEEF_BEEF → mem_* shows the same payload in REQ; mem_reqReady held 0 for 4 cycles keeps mem_reqValid=1 and the payload stable.
- Tie: both reqValid rise in the same cycle after reset → LSU granted first, IFU second; reassert both → LSU again only after IFU has been served (round-robin alternation).
- Back-pressure/ordering: mem_respValid asserted during REQ is ignored; response 5 cycles into WAIT → exactly one respValid pulse, no re-grant in the following IDLE cycle.
- Reset mid-WAIT: assert reset → all outputs are 0 immediately (async); after release, no respValid is issued for the abandoned request and a new IFU request completes normally.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no mem_respValid → respValid and resp_err pulse together with rdata=0xDEADBEEF after 8 WAIT cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the IFU/LSU memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } arb_state_e;

  typedef enum logic {
    GNT_IFU,
    GNT_LSU
  } gnt_e;

  localparam logic [1:0]  SIZE_BYTE = 2'd0;
  localparam logic [1:0]  SIZE_HALF = 2'd1;
  localparam logic [1:0]  SIZE_WORD = 2'd2;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - combinational two-way round-robin picker (IFU vs LSU)
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  gnt_e last_grant,
  output logic grant_valid,
  output gnt_e grant_id
);

  always_comb begin
    grant_valid = ifu_valid | lsu_valid;
    grant_id    = GNT_IFU;
    if (ifu_valid && lsu_valid) begin
      // A tie goes to whoever was not served last.
      grant_id = (last_grant == GNT_IFU) ? GNT_LSU : GNT_IFU;
    end else if (lsu_valid) begin
      grant_id = GNT_LSU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between IFU and LSU requesters
// Optional WAIT-state timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_reqValid,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_respValid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_reqValid,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [1:0]        lsu_size,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wmask,
  output logic              lsu_respValid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_reqValid,
  input  logic              mem_reqReady,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_respValid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e        state_q, state_d;
  gnt_e              last_grant_q;
  logic              grant_valid;
  gnt_e              grant_id;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wmask_q;
  logic [DATA_W-1:0] ifu_rdata_q, lsu_rdata_q;
  logic              timeout_hit;
  logic              resp_take;
  logic [DATA_W-1:0] resp_data;

  arb_rr2 u_arb (
    .ifu_valid   (ifu_reqValid),
    .lsu_valid   (lsu_reqValid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             resp_err_q;

  // Counter sits at zero outside WAIT, so it is cleared on every WAIT entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      resp_err_q <= 1'b0;
    end else begin
      cnt_q      <= (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
      resp_err_q <= timeout_hit;
    end
  end

  assign timeout_hit = (state_q == S_WAIT) && !mem_respValid &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign resp_err    = resp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;
`endif

  assign resp_take = (state_q == S_WAIT) && (mem_respValid || timeout_hit);
  assign resp_data = mem_respValid ? mem_rdata : DATA_W'(TIMEOUT_RDATA);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (grant_valid) state_d = S_REQ;
      S_REQ:  if (mem_reqReady) state_d = S_WAIT;
      S_WAIT: if (resp_take) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= GNT_IFU;
      addr_q       <= '0;
      size_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && grant_valid) begin
        last_grant_q <= grant_id;
        if (grant_id == GNT_LSU) begin
          addr_q  <= lsu_addr;
          size_q  <= lsu_size;
          wen_q   <= lsu_wen;
          wdata_q <= lsu_wdata;
          wmask_q <= lsu_wmask;
        end else begin
          addr_q  <= ifu_addr;
          size_q  <= SIZE_WORD;
          wen_q   <= 1'b0;
          wdata_q <= '0;
          wmask_q <= 4'b1111;
        end
      end
      // Only the granted side's rdata moves; the other keeps its last value.
      if (resp_take) begin
        if (last_grant_q == GNT_LSU) lsu_rdata_q <= resp_data;
        else                         ifu_rdata_q <= resp_data;
      end
    end
  end

  assign mem_reqValid  = (state_q == S_REQ);
  assign mem_addr      = addr_q;
  assign mem_size      = size_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign ifu_respValid = (state_q == S_DONE) && (last_grant_q == GNT_IFU);
  assign lsu_respValid = (state_q == S_DONE) && (last_grant_q == GNT_LSU);
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rdata     = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        mem_reqValid;
  logic        mem_reqReady;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_err    = 0;
  bit m_last_lsu;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .ifu_reqValid  (ifu_reqValid),
    .ifu_addr      (ifu_addr),
    .ifu_respValid (ifu_respValid),
    .ifu_rdata     (ifu_rdata),
    .lsu_reqValid  (lsu_reqValid),
    .lsu_addr      (lsu_addr),
    .lsu_size      (lsu_size),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_respValid (lsu_respValid),
    .lsu_rdata     (lsu_rdata),
    .mem_reqValid  (mem_reqValid),
    .mem_reqReady  (mem_reqReady),
    .mem_addr      (mem_addr),
    .mem_size      (mem_size),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_respValid (mem_respValid),
    .mem_rdata     (mem_rdata),
    .resp_err      (resp_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ifu_resp"}, 32'(ifu_respValid), 0);
    check({tag, "_lsu_resp"}, 32'(lsu_respValid), 0);
    check({tag, "_mem_req"}, 32'(mem_reqValid), 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_ctl"}, {25'd0, mem_size, mem_wen, mem_wmask}, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_ifu_rdata"}, ifu_rdata, 0);
    check({tag, "_lsu_rdata"}, lsu_rdata, 0);
    check({tag, "_resp_err"}, 32'(resp_err), 0);
  endtask

  // Serves exactly one grant starting from IDLE with the current requests applied.
  task automatic serve_one(input int rdy_dly, input int rsp_dly, input bit rsp_in_req,
                           input logic [31:0] rdata);
    bit          g_lsu;
    logic [31:0] e_addr, e_wdata, other_rdata;
    logic [1:0]  e_size;
    logic        e_wen;
    logic [3:0]  e_wmask;
    int          lat;
    g_lsu = (ifu_reqValid && lsu_reqValid) ? !m_last_lsu : lsu_reqValid;
    if (g_lsu) begin
      e_addr = lsu_addr; e_size = lsu_size; e_wen = lsu_wen;
      e_wdata = lsu_wdata; e_wmask = lsu_wmask; other_rdata = ifu_rdata;
    end else begin
      e_addr = ifu_addr; e_size = 2'd2; e_wen = 1'b0;
      e_wdata = 32'd0; e_wmask = 4'b1111; other_rdata = lsu_rdata;
    end
    lat = 0;
    tick(); lat++;
    check("req_valid", 32'(mem_reqValid), 1);
    check("req_addr", mem_addr, e_addr);
    check("req_ctl", {25'd0, mem_size, mem_wen, mem_wmask}, {25'd0, e_size, e_wen, e_wmask});
    check("req_wdata", mem_wdata, e_wdata);
    for (int i = 0; i < rdy_dly; i++) begin
      mem_respValid = rsp_in_req;
      mem_rdata     = $urandom;
      tick(); lat++;
      check("req_hold", 32'(mem_reqValid), 1);
      check("req_addr_stable", mem_addr, e_addr);
      check("req_wdata_stable", mem_wdata, e_wdata);
      check("req_no_resp", {30'd0, ifu_respValid, lsu_respValid}, 0);
    end
    mem_reqReady  = 1'b1;
    mem_respValid = rsp_in_req;
    tick(); lat++;
    mem_reqReady  = 1'b0;
    mem_respValid = 1'b0;
    check("wait_req_low", 32'(mem_reqValid), 0);
    for (int i = 0; i < rsp_dly; i++) begin
      tick(); lat++;
      check("wait_no_resp", {30'd0, ifu_respValid, lsu_respValid}, 0);
    end
    mem_respValid = 1'b1;
    mem_rdata     = rdata;
    tick(); lat++;
    mem_respValid = 1'b0;
    mem_rdata     = $urandom;
    check("latency", 32'(lat), 32'(3 + rdy_dly + rsp_dly));
    check("done_ifu_resp", 32'(ifu_respValid), 32'(!g_lsu));
    check("done_lsu_resp", 32'(lsu_respValid), 32'(g_lsu));
    check("done_resp_err", 32'(resp_err), 0);
    if (!g_lsu) check("done_ifu_rdata", ifu_rdata, rdata);
    else if (!e_wen) check("done_lsu_rdata", lsu_rdata, rdata);
    check("other_rdata_hold", g_lsu ? ifu_rdata : lsu_rdata, other_rdata);
    if (g_lsu) lsu_reqValid = 1'b0;
    else       ifu_reqValid = 1'b0;
    m_last_lsu = g_lsu;
    tick();
    check("idle_no_resp", {30'd0, ifu_respValid, lsu_respValid}, 0);
    check("idle_req_low", 32'(mem_reqValid), 0);
    if (!g_lsu) check("ifu_rdata_hold", ifu_rdata, rdata);
    else if (!e_wen) check("lsu_rdata_hold", lsu_rdata, rdata);
  endtask

  initial begin
    reset = 1'b1;
    ifu_reqValid = 0; ifu_addr = 0;
    lsu_reqValid = 0; lsu_addr = 0; lsu_size = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_reqReady = 0; mem_respValid = 0; mem_rdata = 0;
    m_last_lsu = 1'b0;
    #2;
    check_all_zero("reset");
    tick();
    reset = 1'b0;

    // IFU-only fetch with minimum latency.
    ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0000;
    serve_one(0, 0, 1'b0, 32'h0010_0093);

    // Store held off by four cycles of back-pressure.
    lsu_reqValid = 1'b1; lsu_addr = 32'h100; lsu_size = 2'd2; lsu_wen = 1'b1;
    lsu_wmask = 4'b0011; lsu_wdata = 32'hBEEF_BEEF;
    serve_one(4, 0, 1'b0, 32'h1234_5678);

    // Ties alternate: after the store, LSU was last, so IFU wins this tie; then reset state checks LSU-first below.
    ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_reqValid = 1'b1; lsu_addr = 32'h200; lsu_wen = 1'b0; lsu_size = 2'd1;
    serve_one(0, 1, 1'b0, 32'hA1A1_0001);
    serve_one(1, 0, 1'b0, 32'hA1A1_0002);

    // Response during REQ is ignored; response lands 5 cycles into WAIT.
    ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0010;
    serve_one(2, 5, 1'b1, 32'hC0DE_0005);
    tick();
    check("no_regrant", 32'(mem_reqValid), 0);
    check("no_regrant_resp", {30'd0, ifu_respValid, lsu_respValid}, 0);

    // Reset in the middle of WAIT abandons the transaction.
    ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0020;
    tick();
    mem_reqReady = 1'b1;
    tick();
    mem_reqReady = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    ifu_reqValid = 1'b0;
    m_last_lsu = 1'b0;
    tick();
    reset = 1'b0;
    mem_respValid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_respValid = 1'b0;
      check("abandoned_no_resp", {29'd0, ifu_respValid, lsu_respValid, mem_reqValid}, 0);
    end

    // After reset the first tie goes to LSU, then IFU.
    ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0030;
    lsu_reqValid = 1'b1; lsu_addr = 32'h300; lsu_size = 2'd0; lsu_wen = 1'b0;
    serve_one(0, 0, 1'b0, 32'h5555_0001);
    serve_one(0, 0, 1'b0, 32'h5555_0002);
    ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0034;
    lsu_reqValid = 1'b1; lsu_addr = 32'h304;
    serve_one(0, 0, 1'b0, 32'h5555_0003);
    serve_one(0, 0, 1'b0, 32'h5555_0004);

    // Randomized traffic against the round-robin/scoreboard model.
    for (int it = 0; it < 30; it++) begin
      int pat;
      pat = $urandom_range(1, 3);
      if (pat[0]) begin
        ifu_reqValid = 1'b1;
        ifu_addr     = $urandom & 32'hFFFF_FFFC;
      end
      if (pat[1]) begin
        lsu_reqValid = 1'b1;
        lsu_addr     = $urandom;
        lsu_size     = 2'($urandom_range(0, 2));
        lsu_wen      = 1'($urandom_range(0, 1));
        lsu_wdata    = $urandom;
        lsu_wmask    = 4'($urandom);
      end
      while (ifu_reqValid || lsu_reqValid)
        serve_one($urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0040;
    tick();
    mem_reqReady = 1'b1;
    tick();
    mem_reqReady = 1'b0;
    check("to_wait1", {30'd0, ifu_respValid, resp_err}, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_no_resp", {30'd0, ifu_respValid, resp_err}, 0);
    end
    tick();
    check("to_resp", 32'(ifu_respValid), 1);
    check("to_err", 32'(resp_err), 1);
    check("to_rdata", ifu_rdata, 32'hDEAD_BEEF);
    ifu_reqValid = 1'b0;
    tick();
    check("to_err_clear", {30'd0, ifu_respValid, resp_err}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
